// File: rtl/csr_file_pkg.sv
// Shared CSR definitions: addresses, mstatus layout, write masks and the
// per-port write operation produced by writeback.
package common;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;
  localparam logic [63:0] MIP_WMASK     = 64'h0000_0000_0000_0888;
  localparam logic [63:0] MEPC_WMASK    = 64'hFFFF_FFFF_FFFF_FFFC;

  localparam logic [1:0] PRIV_M = 2'd3;

  typedef struct packed {
    logic [50:0] rsvd_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsvd_mid;
    logic        mpie;
    logic [2:0]  rsvd_lo2;
    logic        mie;
    logic [2:0]  rsvd_lo;
  } mstatus_t;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [63:0] data;
  } csr_op_t;

endpackage

// File: rtl/csr_file_counter.sv
// Free-running XLEN-bit counter with synchronous load; load beats increment.
module csr_counter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            load,
  input  logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] count
);

  logic [XLEN-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)     count_d = load_val;
    else if (inc) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with mret handling and one combinational read port.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters.
module csr_file
  import common::*;
#(
  parameter int unsigned NUM_WR = 3,
  parameter int unsigned XLEN   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_WR-1:0]      we,
  input  logic [NUM_WR*12-1:0]   waddr,
  input  logic [NUM_WR*XLEN-1:0] wdata,
  input  logic                   commit,
  input  logic                   mret,
  input  logic [11:0]            raddr,
  output logic [XLEN-1:0]        rdata,
  output logic [1:0]             mode,
  output logic [XLEN-1:0]        mret_pc,
  output logic [XLEN-1:0]        mstatus_o,
  output logic [XLEN-1:0]        satp_o
);

  csr_op_t ops [NUM_WR];

  mstatus_t        mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] mip_q, mip_d, satp_q, satp_d;
  logic [1:0]      mode_q, mode_d;

`ifdef CSR_COUNTERS_EN
  logic            mcycle_ld, minstret_ld;
  logic [XLEN-1:0] mcycle_val, minstret_val, mcycle_cnt, minstret_cnt;
`else
  logic unused_commit;
  assign unused_commit = commit;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      ops[i].we   = we[i];
      ops[i].addr = waddr[i*12 +: 12];
      ops[i].data = wdata[i*XLEN +: XLEN];
    end
  end

  // Ports are applied in ascending order so the highest index lands last.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mip_d      = mip_q;
    satp_d     = satp_q;
    mode_d     = mode_q;
`ifdef CSR_COUNTERS_EN
    mcycle_ld    = 1'b0;
    minstret_ld  = 1'b0;
    mcycle_val   = '0;
    minstret_val = '0;
`endif
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (ops[i].we) begin
        case (ops[i].addr)
          CSR_MSTATUS:  mstatus_d  = mstatus_t'(ops[i].data & MSTATUS_WMASK);
          CSR_MIE:      mie_d      = ops[i].data;
          CSR_MTVEC:    mtvec_d    = ops[i].data;
          CSR_MSCRATCH: mscratch_d = ops[i].data;
          CSR_MEPC:     mepc_d     = ops[i].data & MEPC_WMASK;
          CSR_MCAUSE:   mcause_d   = ops[i].data;
          CSR_MTVAL:    mtval_d    = ops[i].data;
          CSR_MIP:      mip_d      = ops[i].data & MIP_WMASK;
          CSR_SATP:     satp_d     = ops[i].data;
`ifdef CSR_COUNTERS_EN
          CSR_MCYCLE: begin
            mcycle_ld  = 1'b1;
            mcycle_val = ops[i].data;
          end
          CSR_MINSTRET: begin
            minstret_ld  = 1'b1;
            minstret_val = ops[i].data;
          end
`endif
          default: ;
        endcase
      end
    end
    // mret fields come from the pre-write mstatus and override the write.
    if (mret) begin
      mode_d         = mstatus_q.mpp;
      mstatus_d.mie  = mstatus_q.mpie;
      mstatus_d.mpie = 1'b1;
      mstatus_d.mpp  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
      satp_q     <= '0;
      mode_q     <= PRIV_M;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mip_q      <= mip_d;
      satp_q     <= satp_d;
      mode_q     <= mode_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter #(.XLEN(XLEN)) u_mcycle (
    .clk      (clk),
    .reset    (reset),
    .inc      (1'b1),
    .load     (mcycle_ld),
    .load_val (mcycle_val),
    .count    (mcycle_cnt)
  );

  csr_counter #(.XLEN(XLEN)) u_minstret (
    .clk      (clk),
    .reset    (reset),
    .inc      (commit),
    .load     (minstret_ld),
    .load_val (minstret_val),
    .count    (minstret_cnt)
  );
`endif

  always_comb begin
    rdata = '0;
    case (raddr)
      CSR_MSTATUS:  rdata = mstatus_q;
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MIP:      rdata = mip_q;
      CSR_SATP:     rdata = satp_q;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   rdata = mcycle_cnt;
      CSR_MINSTRET: rdata = minstret_cnt;
`endif
      default:      rdata = '0;
    endcase
  end

  assign mode      = mode_q;
  assign mret_pc   = mepc_q;
  assign mstatus_o = mstatus_q;
  assign satp_o    = satp_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; counter checks follow CSR_COUNTERS_EN.
`timescale 1ns/100ps
module tb_csr_file;

  localparam int unsigned NUM_WR = 3;
  localparam int unsigned XLEN   = 64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_WR-1:0]      we;
  logic [NUM_WR*12-1:0]   waddr;
  logic [NUM_WR*XLEN-1:0] wdata;
  logic                   commit;
  logic                   mret;
  logic [11:0]            raddr;
  logic [XLEN-1:0]        rdata;
  logic [1:0]             mode;
  logic [XLEN-1:0]        mret_pc;
  logic [XLEN-1:0]        mstatus_o;
  logic [XLEN-1:0]        satp_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  csr_file #(.NUM_WR(NUM_WR), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .commit    (commit),
    .mret      (mret),
    .raddr     (raddr),
    .rdata     (rdata),
    .mode      (mode),
    .mret_pc   (mret_pc),
    .mstatus_o (mstatus_o),
    .satp_o    (satp_o)
  );

  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int unsigned port, input logic [11:0] a, input logic [63:0] d);
    we[port]               = 1'b1;
    waddr[port*12 +: 12]   = a;
    wdata[port*XLEN +: XLEN] = d;
  endtask

  task automatic clr_wr();
    we    = '0;
    waddr = '0;
    wdata = '0;
  endtask

  task automatic rd_check(input string tag, input logic [11:0] a, input logic [63:0] exp);
    raddr = a;
    #1;
    check_eq(tag, rdata, exp);
  endtask

  initial begin
    reset  = 1'b1;
    commit = 1'b0;
    mret   = 1'b0;
    raddr  = '0;
    clr_wr();
    step();
    step();
    check_eq("reset_mode", {62'd0, mode}, 64'd3);
    check_eq("reset_mstatus_o", mstatus_o, 64'd0);
    check_eq("reset_satp_o", satp_o, 64'd0);
    check_eq("reset_mret_pc", mret_pc, 64'd0);
    rd_check("reset_mtvec", 12'h305, 64'd0);
    reset = 1'b0;

`ifdef CSR_COUNTERS_EN
    rd_check("mcycle_first", 12'hB00, 64'd0);
    step();
    rd_check("mcycle_second", 12'hB00, 64'd1);
    step();
    rd_check("mcycle_third", 12'hB00, 64'd2);
`endif

    set_wr(0, 12'h305, 64'h8000_0100);
    step();
    clr_wr();
    rd_check("mtvec_wr", 12'h305, 64'h8000_0100);
    rd_check("others_mstatus", 12'h300, 64'd0);
    rd_check("others_mie", 12'h304, 64'd0);
    rd_check("others_mscratch", 12'h340, 64'd0);
    rd_check("others_mepc", 12'h341, 64'd0);
    rd_check("others_mcause", 12'h342, 64'd0);
    rd_check("others_mtval", 12'h343, 64'd0);
    rd_check("others_mip", 12'h344, 64'd0);
    rd_check("others_satp", 12'h180, 64'd0);
    check_eq("mode_still_m", {62'd0, mode}, 64'd3);

    set_wr(0, 12'h340, 64'h11);
    set_wr(2, 12'h340, 64'h22);
    step();
    clr_wr();
    rd_check("mscratch_prio", 12'h340, 64'h22);

    set_wr(1, 12'h340, 64'h33);
    set_wr(2, 12'h342, 64'h5);
    step();
    clr_wr();
    rd_check("mscratch_p1", 12'h340, 64'h33);
    rd_check("mcause_p2", 12'h342, 64'h5);

    set_wr(0, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    set_wr(1, 12'h341, 64'h1003);
    set_wr(2, 12'h180, 64'hDEAD_BEEF_0000_0001);
    step();
    clr_wr();
    rd_check("mstatus_mask", 12'h300, 64'h1888);
    check_eq("mstatus_o_mask", mstatus_o, 64'h1888);
    rd_check("mepc_mask", 12'h341, 64'h1000);
    check_eq("mret_pc_mask", mret_pc, 64'h1000);
    check_eq("satp_o", satp_o, 64'hDEAD_BEEF_0000_0001);

    set_wr(0, 12'h344, 64'hFFFF_FFFF_FFFF_FFFF);
    set_wr(1, 12'h7C0, 64'h1234);
    step();
    clr_wr();
    rd_check("mip_mask", 12'h344, 64'h888);
    rd_check("unimpl_rd", 12'h7C0, 64'd0);

    set_wr(0, 12'h300, 64'h80);
    set_wr(1, 12'h341, 64'h2000);
    step();
    clr_wr();
    check_eq("pre_mret_mstatus", mstatus_o, 64'h80);
    mret = 1'b1;
    step();
    mret = 1'b0;
    check_eq("mret_mode", {62'd0, mode}, 64'd0);
    check_eq("mret_mstatus", mstatus_o, 64'h88);
    check_eq("mret_pc", mret_pc, 64'h2000);

    // MPIE=1, MPP=0 now; the concurrent write's MIE/MPIE/MPP must lose.
    set_wr(0, 12'h300, 64'h1800);
    mret = 1'b1;
    step();
    mret = 1'b0;
    clr_wr();
    check_eq("mret_vs_wr_mstatus", mstatus_o, 64'h88);
    check_eq("mret_vs_wr_mode", {62'd0, mode}, 64'd0);

`ifdef CSR_COUNTERS_EN
    commit = 1'b1;
    for (int i = 0; i < 5; i++) step();
    commit = 1'b0;
    step();
    rd_check("minstret_5", 12'hB02, 64'd5);

    set_wr(1, 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
    commit = 1'b1;
    step();
    commit = 1'b0;
    clr_wr();
    rd_check("minstret_ld_beats_inc", 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
    commit = 1'b1;
    step();
    commit = 1'b0;
    rd_check("minstret_wrap", 12'hB02, 64'd0);

    set_wr(2, 12'hB00, 64'd100);
    step();
    clr_wr();
    rd_check("mcycle_load", 12'hB00, 64'd100);
    step();
    rd_check("mcycle_resume", 12'hB00, 64'd101);
`else
    set_wr(0, 12'hB00, 64'd100);
    set_wr(1, 12'hB02, 64'd7);
    commit = 1'b1;
    step();
    step();
    commit = 1'b0;
    clr_wr();
    rd_check("no_mcycle", 12'hB00, 64'd0);
    rd_check("no_minstret", 12'hB02, 64'd0);
`endif

    reset  = 1'b1;
    mret   = 1'b1;
    commit = 1'b1;
    set_wr(0, 12'h340, 64'hABCD);
    step();
    reset  = 1'b0;
    mret   = 1'b0;
    commit = 1'b0;
    clr_wr();
    rd_check("midrst_mscratch", 12'h340, 64'd0);
    check_eq("midrst_mode", {62'd0, mode}, 64'd3);
    check_eq("midrst_mstatus", mstatus_o, 64'd0);
`ifdef CSR_COUNTERS_EN
    rd_check("midrst_minstret", 12'hB02, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
